// File: rtl/cfg_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package cfg_loader_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_IDX_W = $clog2(BYTE_W);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_e;

  // Width needed to count 0..chain_len inclusive.
  function automatic int unsigned cnt_width(input int unsigned chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/cfg_piso8.sv
// 8-bit parallel-load / shift-left register; the MSB is the next serial bit.
module cfg_piso8
  import cfg_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [BYTE_W-1:0] din,
  output logic              msb
);

  logic [BYTE_W-1:0] shreg;

  // Load wins over shift so a back-to-back byte replaces the emptied register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[BYTE_W-2:0], 1'b0};
    end
  end

  assign msb = shreg[BYTE_W-1];

endmodule

// File: rtl/cfg_chain_loader.sv
// Byte-stream to serial configuration-chain writer: bytes in over valid/ready,
// bits out MSB-first to the fabric chain head with a per-bit shift enable.
module cfg_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 96,
  parameter int unsigned CNT_W     = cnt_width(CHAIN_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              prog_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_loaded
);

  localparam logic [CNT_W-1:0]     LAST_IDX  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(BYTE_W - 1);

  state_e               state_q, state_d;
  logic [BIT_IDX_W-1:0] byte_bit_q, byte_bit_d;
  logic [CNT_W-1:0]     cnt_d;
  logic                 ccff_d, prog_en_d, busy_d, done_d;
  logic                 load, shift, msb;
  logic                 byte_last, chain_last, hs;

  cfg_piso8 u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (shift),
    .din   (s_data),
    .msb   (msb)
  );

  assign chain_last = (bits_loaded == LAST_IDX);
  assign byte_last  = (byte_bit_q == LAST_BIT) || chain_last;

  // Ready only when a new byte can be taken without a bubble; abort suppresses it.
  assign s_ready = !abort &&
                   ((state_q == FETCH) ||
                    ((state_q == SHIFT) && byte_last && !chain_last));
  assign hs = s_valid && s_ready;

  always_comb begin
    state_d    = state_q;
    byte_bit_d = byte_bit_q;
    cnt_d      = bits_loaded;
    ccff_d     = ccff_head;
    prog_en_d  = 1'b0;
    busy_d     = busy;
    done_d     = done;
    load       = 1'b0;
    shift      = 1'b0;

    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          // Completion flags settle one edge after the final shift enable.
          if (state_q == DONE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
          if (start) begin
            state_d = FETCH;
            cnt_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end

        FETCH: begin
          if (hs) begin
            load       = 1'b1;
            byte_bit_d = '0;
            state_d    = SHIFT;
          end
        end

        SHIFT: begin
          shift      = 1'b1;
          ccff_d     = msb;
          prog_en_d  = 1'b1;
          cnt_d      = bits_loaded + CNT_W'(1);
          byte_bit_d = byte_bit_q + BIT_IDX_W'(1);
          if (chain_last) begin
            state_d = DONE;
          end else if (byte_last) begin
            if (hs) begin
              load       = 1'b1;
              byte_bit_d = '0;
            end else begin
              state_d = FETCH;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byte_bit_q  <= '0;
      bits_loaded <= '0;
      ccff_head   <= 1'b0;
      prog_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_bit_q  <= byte_bit_d;
      bits_loaded <= cnt_d;
      ccff_head   <= ccff_d;
      prog_en     <= prog_en_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench for cfg_chain_loader: a 16-bit and a 12-bit chain instance.
module tb_cfg_chain_loader;

  logic       clk;
  logic       rst_n;
  logic [1:0] start, abort, s_valid, s_ready, ccff, prog_en, busy, done;
  logic [7:0] s_data;
  logic [4:0] bl16;
  logic [3:0] bl12;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit q0[$];
  bit q1[$];
  int n_sh[2];
  int first_c[2];
  int last_c[2];
  int pushed_n[2];

  cfg_chain_loader #(.CHAIN_LEN(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .s_data(s_data), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .ccff_head(ccff[0]), .prog_en(prog_en[0]), .busy(busy[0]),
    .done(done[0]), .bits_loaded(bl16)
  );

  cfg_chain_loader #(.CHAIN_LEN(12)) u12 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .s_data(s_data), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .ccff_head(ccff[1]), .prog_en(prog_en[1]), .busy(busy[1]),
    .done(done[1]), .bits_loaded(bl12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int clen(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  function automatic int bl(input int d);
    return (d == 0) ? int'(bl16) : int'(bl12);
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic bit qpop(input int d);
    return (d == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  function automatic void qflush(input int d);
    if (d == 0) q0.delete();
    else q1.delete();
  endfunction

  // Reference model: a byte contributes its MSBs until the chain is full.
  function automatic void push_byte(input int d, input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (pushed_n[d] < clen(d)) begin
        if (d == 0) q0.push_back(b[7-i]);
        else q1.push_back(b[7-i]);
        pushed_n[d]++;
      end
    end
  endfunction

  // Monitor: every shift-enabled cycle must carry the next expected bit.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (prog_en[d]) begin
          n_sh[d]++;
          if (first_c[d] < 0) first_c[d] = cyc;
          last_c[d] = cyc;
          chk($sformatf("bit_expected_d%0d", d), int'(qsize(d) > 0), 1);
          if (qsize(d) > 0) chk($sformatf("ccff_head_d%0d", d), int'(ccff[d]), int'(qpop(d)));
        end
      end
    end
  end

  task automatic send(input int d, input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      s_valid[d] = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (!s_ready[d] && t < 64);
      repeat (gap) @(posedge clk);
      #1;
    end
    s_data = b;
    s_valid[d] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!s_ready[d] && t < 64);
    chk("handshake", int'(s_ready[d]), 1);
    if (s_ready[d]) push_byte(d, b);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
  endtask

  task automatic begin_load(input int d, output int st_cyc);
    n_sh[d] = 0;
    first_c[d] = -1;
    pushed_n[d] = 0;
    qflush(d);
    st_cyc = cyc;
    pulse_start(d);
    chk("start_busy", int'(busy[d]), 1);
    chk("start_bits", bl(d), 0);
    chk("start_done", int'(done[d]), 0);
  endtask

  task automatic run_load(input int d, input logic [7:0] b0, input logic [7:0] b1, input int g1);
    int st_cyc;
    int t;
    begin_load(d, st_cyc);
    send(d, b0, 0);
    send(d, b1, g1);
    s_valid[d] = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!done[d] && t < 100);
    chk("done", int'(done[d]), 1);
    chk("busy_after_done", int'(busy[d]), 0);
    chk("done_one_after_last_bit", cyc - last_c[d], 1);
    chk("prog_en_dropped", int'(prog_en[d]), 0);
    chk("bits_loaded_final", bl(d), clen(d));
    chk("shift_count", n_sh[d], clen(d));
    chk("queue_drained", qsize(d), 0);
    chk("first_bit_latency", first_c[d] - st_cyc, 3);
    if (g1 == 0) chk("back_to_back_span", last_c[d] - first_c[d], clen(d) - 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bits(input int d, input int target);
    int t = 0;
    while (bl(d) != target && t < 64) begin
      @(negedge clk);
      t++;
    end
    chk("wait_bits", bl(d), target);
  endtask

  initial begin
    int st_cyc;
    rst_n = 1'b0;
    start = '0;
    abort = '0;
    s_valid = '0;
    s_data = '0;
    for (int d = 0; d < 2; d++) begin
      n_sh[d] = 0;
      first_c[d] = -1;
      last_c[d] = 0;
      pushed_n[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_s_ready", int'(s_ready[d]), 0);
      chk("rst_ccff", int'(ccff[d]), 0);
      chk("rst_prog_en", int'(prog_en[d]), 0);
      chk("rst_busy", int'(busy[d]), 0);
      chk("rst_done", int'(done[d]), 0);
      chk("rst_bits", bl(d), 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back 16-bit load, then partial final byte on the 12-bit chain.
    run_load(0, 8'hA5, 8'h3C, 0);
    run_load(1, 8'hFF, 8'h9F, 0);
    s_data = 8'h77;
    s_valid[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_ready_in_done", int'(s_ready[1]), 0);
      chk("done_held", int'(done[1]), 1);
    end
    s_valid[1] = 1'b0;
    @(posedge clk);
    #1;

    // Stalled second byte.
    run_load(0, 8'hC3, 8'h5A, 3);

    // Abort after five bits, then a fresh load.
    begin_load(0, st_cyc);
    send(0, 8'hE7, 0);
    s_valid[0] = 1'b0;
    wait_bits(0, 5);
    abort[0] = 1'b1;
    @(posedge clk);
    #1;
    abort[0] = 1'b0;
    @(negedge clk);
    chk("abort_prog_en", int'(prog_en[0]), 0);
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_done", int'(done[0]), 0);
    chk("abort_bits_held", bl(0), 5);
    chk("abort_s_ready", int'(s_ready[0]), 0);
    chk("abort_shift_count", n_sh[0], 5);
    qflush(0);
    @(posedge clk);
    #1;
    run_load(0, 8'h81, 8'h7E, 0);

    // Start while busy is ignored.
    fork
      run_load(0, 8'h96, 8'h69, 0);
      begin
        repeat (6) @(posedge clk);
        #1;
        pulse_start(0);
      end
    join

    // Start and abort together mid-load: abort wins.
    begin_load(1, st_cyc);
    send(1, 8'h3A, 0);
    s_valid[1] = 1'b0;
    wait_bits(1, 2);
    start[1] = 1'b1;
    abort[1] = 1'b1;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    abort[1] = 1'b0;
    @(negedge clk);
    chk("sa_busy", int'(busy[1]), 0);
    chk("sa_prog_en", int'(prog_en[1]), 0);
    chk("sa_done", int'(done[1]), 0);
    chk("sa_s_ready", int'(s_ready[1]), 0);
    qflush(1);
    repeat (2) @(negedge clk);
    chk("sa_still_idle", int'(busy[1]), 0);
    chk("sa_still_no_ready", int'(s_ready[1]), 0);
    @(posedge clk);
    #1;

    // Asynchronous reset between clock edges during shifting.
    begin_load(0, st_cyc);
    send(0, 8'hFF, 0);
    s_valid[0] = 1'b0;
    wait_bits(0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ccff", int'(ccff[0]), 0);
    chk("arst_prog_en", int'(prog_en[0]), 0);
    chk("arst_busy", int'(busy[0]), 0);
    chk("arst_done", int'(done[0]), 0);
    chk("arst_bits", bl(0), 0);
    chk("arst_s_ready", int'(s_ready[0]), 0);
    qflush(0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_s_ready", int'(s_ready[0]), 0);
    chk("post_rst_busy", int'(busy[0]), 0);
    @(posedge clk);
    #1;

    // Randomized loads on both chains.
    for (int k = 0; k < 6; k++) begin
      for (int d = 0; d < 2; d++) begin
        run_load(d, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
